// File: rtl/jump_pc_sequencer_pkg.sv
// Shared widths, FSM encoding and jump-target helper for the jump-target fetch path.
package jump_pc_sequencer_pkg;

  localparam int ADDR_W      = 8;
  localparam int JFIELD_W    = 5;
  localparam int INSTR_BYTES = 4;
  localparam int INSTR_W     = 8 * INSTR_BYTES;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // The jump field is a word index, so the byte target is the field shifted up two bits.
  function automatic logic [ADDR_W-1:0] jump_target(input logic [JFIELD_W-1:0] field);
    logic [ADDR_W-1:0] ext;
    ext = {{(ADDR_W-JFIELD_W){1'b0}}, field};
    return ext << 2;
  endfunction

endpackage

// File: rtl/jump_pc_sequencer_if.sv
// Bus bundle between the PC sequencer (master) and its memory/decoder environment (slave).
interface jump_pc_sequencer_if;
  import jump_pc_sequencer_pkg::*;

  // mem_req/mem_ack: a byte transfer completes in any cycle with mem_req && mem_ack;
  // mem_addr is stable while mem_req is high. instr_valid/instr_ready: a word is
  // consumed in any cycle with both high; instr and instr_pc stay stable until then.
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [7:0]          mem_rdata;
  logic                instr_valid;
  logic                instr_ready;
  logic [INSTR_W-1:0]  instr;
  logic [ADDR_W-1:0]   instr_pc;
  logic                jump_valid;
  logic [JFIELD_W-1:0] jump_field;
  state_t              dbg_state;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc, dbg_state,
    input  mem_ack, mem_rdata, instr_ready, jump_valid, jump_field
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc, dbg_state,
    output mem_ack, mem_rdata, instr_ready, jump_valid, jump_field
  );

endinterface

// File: rtl/jump_pc_sequencer_instr_byte_assembler.sv
// Collects four little-endian bytes into one instruction word; byte_cnt selects the lane.
module jump_pc_sequencer_instr_byte_assembler
  import jump_pc_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] word,
  output logic [1:0]         byte_cnt
);

  logic [INSTR_BYTES-1:0][7:0] lanes;

  // byte_cnt wraps to zero on the fourth load, ready for the next word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes    <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (load) begin
      lanes[byte_cnt] <= data;
      byte_cnt        <= byte_cnt + 2'd1;
    end
  end

  assign word = lanes;

endmodule

// File: rtl/jump_pc_sequencer.sv
// Owns the PC: fetches 4-byte instructions over req/ack, presents them over
// valid/ready, and redirects to the decoder's jump target.
module jump_pc_sequencer
  import jump_pc_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input logic                 clk,
  input logic                 reset,
  jump_pc_sequencer_if.master bus
);

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  mem_addr;
  logic [ADDR_W-1:0]  instr_pc;
  logic [ADDR_W-1:0]  flush_tgt;
  logic               mem_req;
  logic               instr_valid;
  logic               flush;
  logic [1:0]         byte_cnt;
  logic [INSTR_W-1:0] word;
  logic [ADDR_W-1:0]  tgt;
  logic               load;
  logic               clear;

  assign tgt = jump_target(bus.jump_field);

  // A byte is kept only if no redirect is pending or arriving with its ack.
  always_comb begin
    load  = 1'b0;
    clear = 1'b0;
    if (state == HOLD) begin
      clear = bus.jump_valid || bus.instr_ready;
    end else if (mem_req && bus.mem_ack) begin
      if (flush || bus.jump_valid) clear = 1'b1;
      else                         load  = 1'b1;
    end else if (!mem_req) begin
      clear = bus.jump_valid;
    end
  end

  jump_pc_sequencer_instr_byte_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .clear    (clear),
    .data     (bus.mem_rdata),
    .word     (word),
    .byte_cnt (byte_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      flush       <= 1'b0;
      flush_tgt   <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr_pc    <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
            if (bus.jump_valid) begin
              pc       <= tgt;
              mem_addr <= tgt;
            end else begin
              mem_addr <= pc + ADDR_W'(byte_cnt);
            end
          end else if (bus.mem_ack) begin
            mem_req <= 1'b0;
            flush   <= 1'b0;
            if (bus.jump_valid) begin
              pc <= tgt;
            end else if (flush) begin
              pc <= flush_tgt;
            end else if (byte_cnt == 2'(INSTR_BYTES-1)) begin
              state       <= HOLD;
              instr_valid <= 1'b1;
              instr_pc    <= pc;
              pc          <= pc + ADDR_W'(INSTR_BYTES);
            end
          end else if (bus.jump_valid) begin
            // The outstanding read cannot be cancelled; remember where to go after it.
            flush     <= 1'b1;
            flush_tgt <= tgt;
          end
        end
        HOLD: begin
          if (bus.jump_valid) begin
            pc          <= tgt;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (bus.instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = mem_addr;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = word;
  assign bus.instr_pc    = instr_pc;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_jump_pc_sequencer.sv
// Randomized bench for jump_pc_sequencer: memory responder, jump/ready driver,
// word-level reference model and a decoupled scoreboard monitor.
module tb_jump_pc_sequencer;
  import jump_pc_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  jump_pc_sequencer_if bus();

  jump_pc_sequencer #(.RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_hs    = 0;

  logic [7:0]                mem [256];
  logic [ADDR_W-1:0]         exp_addr_q[$];
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];

  // reference model: next byte address to be requested and the word being built
  logic [ADDR_W-1:0]  m_next;
  logic [ADDR_W-1:0]  m_word_pc;
  logic [ADDR_W-1:0]  m_held_pc;
  logic [INSTR_W-1:0] m_word;
  logic [INSTR_W-1:0] m_held;
  int                 m_cnt;
  bit                 m_hold;
  bit                 m_discard;

  bit drv_prev_req, drv_prev_ack, first_after_reset;
  int lat, jump_pct, ready_pct;

  bit                        mon_prev_req, mon_prev_ack;
  logic [ADDR_W-1:0]         mon_cur_addr;
  logic [ADDR_W+INSTR_W-1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_next = 8'h00; m_word_pc = 8'h00; m_held_pc = 8'h00;
    m_word = '0; m_held = '0; m_cnt = 0; m_hold = 0; m_discard = 0;
    exp_q.delete(); exp_addr_q.delete();
    drv_prev_req = 0; drv_prev_ack = 0; lat = 0;
  endtask

  task automatic idle_inputs();
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; bus.instr_ready = 1'b0;
    bus.jump_valid = 1'b0; bus.jump_field = '0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_mem_req"},     64'(bus.mem_req),     64'h0);
    check({tag, "_mem_addr"},    64'(bus.mem_addr),    64'h00);
    check({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'h0);
    check({tag, "_instr"},       64'(bus.instr),       64'h0);
    check({tag, "_instr_pc"},    64'(bus.instr_pc),    64'h00);
    check({tag, "_state"},       64'(bus.dbg_state),   64'(FETCH));
  endtask

  // ---------------- driver + responder + model ----------------
  task automatic drive_cycle();
    logic req, ack, jv, rdy;
    logic [ADDR_W-1:0]   addr, tgt;
    logic [JFIELD_W-1:0] jf;
    @(negedge clk);
    req  = bus.mem_req;
    addr = bus.mem_addr;
    if (first_after_reset) begin
      check("first_req", 64'(req), 64'h1);
      first_after_reset = 0;
    end
    check("valid_vs_model", 64'(bus.instr_valid), 64'(m_hold));

    ack = 1'b0;
    if (req) begin
      if (!drv_prev_req || drv_prev_ack) lat = $urandom_range(0, 3);
      if (lat == 0) ack = 1'b1;
      else          lat--;
    end else begin
      ack = ($urandom_range(0, 19) == 0);
    end
    jv  = ($urandom_range(0, 99) < jump_pct);
    jf  = JFIELD_W'($urandom);
    rdy = ($urandom_range(0, 99) < ready_pct);

    bus.mem_ack     = ack;
    bus.mem_rdata   = req ? mem[addr] : 8'($urandom);
    bus.jump_valid  = jv;
    bus.jump_field  = jf;
    bus.instr_ready = rdy;

    tgt = ADDR_W'(int'(jf) * 4);
    if (req && (!drv_prev_req || drv_prev_ack)) exp_addr_q.push_back(m_next);

    if (m_hold) begin
      if (jv) begin
        m_hold = 0; m_next = tgt; m_cnt = 0;
      end else if (rdy) begin
        exp_q.push_back({m_held_pc, m_held});
        m_hold = 0;
      end
    end else if (req && ack) begin
      if (m_discard || jv) begin
        m_discard = 0; m_cnt = 0;
        if (jv) m_next = tgt;
      end else begin
        if (m_cnt == 0) m_word_pc = m_next;
        m_word[8*m_cnt +: 8] = mem[m_next];
        m_next = m_next + 8'd1;
        m_cnt++;
        if (m_cnt == INSTR_BYTES) begin
          m_hold = 1; m_held = m_word; m_held_pc = m_word_pc; m_cnt = 0;
        end
      end
    end else if (jv) begin
      m_next = tgt; m_cnt = 0;
      if (req) m_discard = 1;
    end

    drv_prev_req = req;
    drv_prev_ack = ack;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    mon_prev_req = 0; mon_prev_ack = 0; mon_cur_addr = '0; mon_e = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        mon_prev_req = 0;
        mon_prev_ack = 0;
      end else begin
        if (bus.mem_req && (!mon_prev_req || mon_prev_ack)) begin
          if (exp_addr_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL req_unexpected: got request at %0h, expected none", bus.mem_addr);
          end else begin
            mon_cur_addr = exp_addr_q.pop_front();
            check("req_addr", 64'(bus.mem_addr), 64'(mon_cur_addr));
          end
        end else if (bus.mem_req) begin
          check("addr_hold", 64'(bus.mem_addr), 64'(mon_cur_addr));
        end
        if (mon_prev_req && mon_prev_ack) check("req_gap", 64'(bus.mem_req), 64'h0);
        if (bus.instr_valid && bus.instr_ready && !bus.jump_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL instr_unexpected: got %0h at pc %0h, expected none", bus.instr, bus.instr_pc);
          end else begin
            mon_e = exp_q.pop_front();
            check("instr",    64'(bus.instr),    64'(mon_e[INSTR_W-1:0]));
            check("instr_pc", 64'(bus.instr_pc), 64'(mon_e[ADDR_W+INSTR_W-1 -: ADDR_W]));
            n_hs++;
          end
        end
        mon_prev_req = bus.mem_req;
        mon_prev_ack = bus.mem_ack;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int start, cyc;
    bit found;
    foreach (mem[i]) mem[i] = 8'($urandom);
    idle_inputs();
    model_reset();
    jump_pct = 0; ready_pct = 100; first_after_reset = 0;

    repeat (3) @(negedge clk);
    reset_checks("por");
    reset = 1'b1;
    first_after_reset = 1;

    repeat (40)   drive_cycle();
    jump_pct = 3;  ready_pct = 60;
    repeat (1500) drive_cycle();
    jump_pct = 15; ready_pct = 30;
    repeat (800)  drive_cycle();

    // reset while byte 1 of a word is in flight
    jump_pct = 0; ready_pct = 100; found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      drive_cycle();
      if (bus.mem_req && m_cnt == 1 && !m_hold && !m_discard && !drv_prev_ack) found = 1;
    end
    check("midfetch_found", 64'(found), 64'h1);
    #3 reset = 1'b0;
    #1;
    check("async_mem_req",     64'(bus.mem_req),     64'h0);
    check("async_instr_valid", 64'(bus.instr_valid), 64'h0);
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("midrst");
    reset = 1'b1;
    first_after_reset = 1;

    // long straight-line run so the PC wraps past FC
    start = n_hs; cyc = 0;
    while ((n_hs - start) < 70 && cyc < 4000) begin
      drive_cycle();
      cyc++;
    end
    check("wrap_run_words", 64'((n_hs - start) >= 70), 64'h1);
    repeat (4) drive_cycle();

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    check("liveness", 64'(n_hs >= 100), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
